bcd_field_editor: RTL and testbench

- Parametrised user-edit controller for the clock/timer front panel.
- Holds NUM_FIELDS two-digit BCD fields (day, month, year, hh, mm, ss, timer hh/mm/ss, ...) in shadow registers.
- Moves a cursor over a selectable field window, increments/decrements with per-field min/max wrap and auto-repeat on held buttons, then commits or cancels.
- Sits between the debounced button inputs and the RTC/timer register-write path.

---
 rtl/bcd_edit_pkg.sv | 18 +
 rtl/btn_repeat.sv | 38 +++
 rtl/bcd_field_editor.sv | 111 +++++++++++
 tb/tb_bcd_field_editor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_edit_pkg.sv
// bcd_edit_pkg: shared state encoding and BCD step helpers for the field editor.
package bcd_edit_pkg;

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] min, input logic [7:0] max);
        return (val >= max) ? min : (val[3:0] == 4'h9) ? val + 8'h07 : val + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] min, input logic [7:0] max);
        return (val <= min) ? max : (val[3:0] == 4'h0) ? val - 8'h07 : val - 8'h01;
    endfunction

    function automatic int fld_lsb(input int i);
        return 8 * i;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: rising-edge step generator with optional hold-to-repeat.
module btn_repeat #(
    parameter bit REPEAT_EN   = 1'b0,
    parameter int REPEAT_DLY  = 50000000,
    parameter int REPEAT_RATE = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic step
);

    localparam int CW = $clog2((REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE) + 1);

    logic          prev;
    logic [CW-1:0] cnt;
    logic          edge_det;
    logic          rep;

    assign edge_det = btn & ~prev;
    // cnt counts down the remaining hold cycles; zero while held means a repeat is due
    assign rep = REPEAT_EN && btn && !edge_det && !clr && (cnt == '0);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            prev <= 1'b0;
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            prev <= btn;
            step <= edge_det | rep;
            cnt  <= (edge_det || clr) ? CW'(REPEAT_DLY - 1) :
                    rep               ? CW'(REPEAT_RATE - 1) :
                    (btn && cnt != '0) ? cnt - CW'(1) : cnt;
        end

endmodule

// File: rtl/bcd_field_editor.sv
// bcd_field_editor: front-panel edit controller for a window of two-digit BCD fields
// with cursor, per-field wrap, auto-repeat, max-clamp and commit/cancel.
module bcd_field_editor
    import bcd_edit_pkg::*;
#(
    parameter int NUM_FIELDS  = 9,
    parameter int ADDR_W      = 4,
    parameter int REPEAT_DLY  = 50000000,
    parameter int REPEAT_RATE = 10000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       first_fld,
    input  logic [ADDR_W-1:0]       last_fld,
    input  logic [NUM_FIELDS*8-1:0] live_vals,
    input  logic [NUM_FIELDS*8-1:0] fld_min,
    input  logic [NUM_FIELDS*8-1:0] fld_max,
    input  logic                    btn_ok,
    input  logic                    btn_esc,
    input  logic                    btn_r,
    input  logic                    btn_l,
    input  logic                    btn_u,
    input  logic                    btn_d,
    output logic [NUM_FIELDS*8-1:0] edit_vals,
    output logic [ADDR_W-1:0]       cursor,
    output logic                    editing,
    output logic                    commit
);

    state_t                  state, state_nx;
    logic [ADDR_W-1:0]       first_q, last_q, first_nx, last_nx, cur_nx;
    logic [NUM_FIELDS*8-1:0] vals_nx;
    logic                    ok_s, esc_s, r_s, l_s, u_s, d_s;
    logic                    ud_clr, act_ud;

    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE))
        u_ok  (.clk(clk), .reset(reset), .btn(btn_ok),  .clr(1'b0),   .step(ok_s));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE))
        u_esc (.clk(clk), .reset(reset), .btn(btn_esc), .clr(1'b0),   .step(esc_s));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE))
        u_r   (.clk(clk), .reset(reset), .btn(btn_r),   .clr(1'b0),   .step(r_s));
    btn_repeat #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE))
        u_l   (.clk(clk), .reset(reset), .btn(btn_l),   .clr(1'b0),   .step(l_s));
    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE))
        u_u   (.clk(clk), .reset(reset), .btn(btn_u),   .clr(ud_clr), .step(u_s));
    btn_repeat #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE))
        u_d   (.clk(clk), .reset(reset), .btn(btn_d),   .clr(ud_clr), .step(d_s));

    assign editing = (state == EDIT);
    assign commit  = (state == COMMIT);

    always_comb begin
        state_nx = state;
        first_nx = first_q;
        last_nx  = last_q;
        cur_nx   = cursor;
        vals_nx  = edit_vals;
        ud_clr   = 1'b0;
        act_ud   = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nx = EDIT;
                first_nx = first_fld;
                last_nx  = last_fld;
                cur_nx   = first_fld;
                vals_nx  = live_vals;
            end
            EDIT: begin
                ud_clr = (u_s & d_s) | (~esc_s & ~ok_s & (r_s ^ l_s));
                if (esc_s)
                    state_nx = IDLE;
                else if (ok_s)
                    state_nx = COMMIT;
                else if (r_s || l_s)
                    cur_nx = (r_s == l_s) ? cursor :
                             r_s ? ((cursor == last_q) ? first_q : cursor + ADDR_W'(1)) :
                                   ((cursor == first_q) ? last_q : cursor - ADDR_W'(1));
                else
                    act_ud = u_s ^ d_s;
                // a step on the cursor field wins over the clamp; the clamp catches it next cycle
                for (int i = 0; i < NUM_FIELDS; i++)
                    if (ADDR_W'(i) >= first_q && ADDR_W'(i) <= last_q) begin
                        if (act_ud && cursor == ADDR_W'(i))
                            vals_nx[fld_lsb(i) +: 8] = u_s ?
                                bcd_inc(edit_vals[fld_lsb(i) +: 8], fld_min[fld_lsb(i) +: 8], fld_max[fld_lsb(i) +: 8]) :
                                bcd_dec(edit_vals[fld_lsb(i) +: 8], fld_min[fld_lsb(i) +: 8], fld_max[fld_lsb(i) +: 8]);
                        else if (edit_vals[fld_lsb(i) +: 8] > fld_max[fld_lsb(i) +: 8])
                            vals_nx[fld_lsb(i) +: 8] = fld_max[fld_lsb(i) +: 8];
                    end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            first_q   <= '0;
            last_q    <= '0;
            cursor    <= '0;
            edit_vals <= '0;
        end else begin
            state     <= state_nx;
            first_q   <= first_nx;
            last_q    <= last_nx;
            cursor    <= cur_nx;
            edit_vals <= vals_nx;
        end

endmodule

// File: tb/tb_bcd_field_editor.sv
// tb_bcd_field_editor: scoreboard bench; every change of the DUT outputs is matched
// against the next queued expectation (optionally at an exact cycle).
module tb_bcd_field_editor;

    localparam int NF = 9;
    localparam int AW = 4;
    localparam int OW = 2 + AW + NF * 8;

    typedef struct {
        logic [OW-1:0] obs;
        int            cyc;
        string         name;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   first_fld = '0, last_fld = '0;
    logic [NF*8-1:0] live_vals, fld_min, fld_max;
    logic            btn_ok = 1'b0, btn_esc = 1'b0, btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic [NF*8-1:0] edit_vals;
    logic [AW-1:0]   cursor;
    logic            editing, commit;

    logic            e_edit = 1'b0, e_commit = 1'b0;
    logic [AW-1:0]   e_cur = '0;
    logic [NF*8-1:0] e_vals = '0;
    exp_t            q[$];
    exp_t            e;
    logic [OW-1:0]   prev, cur;
    logic            mon_en = 1'b0;
    int              cyc = 0, n_cmp = 0, n_bad = 0, n_commit = 0, n0;

    bcd_field_editor #(.NUM_FIELDS(NF), .ADDR_W(AW), .REPEAT_DLY(10), .REPEAT_RATE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .first_fld(first_fld), .last_fld(last_fld),
        .live_vals(live_vals), .fld_min(fld_min), .fld_max(fld_max),
        .btn_ok(btn_ok), .btn_esc(btn_esc), .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
        .edit_vals(edit_vals), .cursor(cursor), .editing(editing), .commit(commit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (commit) n_commit++;

    always @(negedge clk) if (mon_en) begin
        cur = {editing, commit, cursor, edit_vals};
        if (cur !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: got %h at cycle %0d, nothing expected", cur, cyc);
            end else begin
                e = q.pop_front();
                if (cur !== e.obs || (e.cyc >= 0 && e.cyc != cyc)) begin
                    n_bad++;
                    $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", e.name, cur, cyc, e.obs, e.cyc);
                end
            end
            prev = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input int c);
        exp_t x;
        x.obs  = {e_edit, e_commit, e_cur, e_vals};
        x.cyc  = c;
        x.name = nm;
        q.push_back(x);
    endtask

    // mask order {ok, esc, r, l, u, d}
    task automatic press(input logic [5:0] m);
        {btn_ok, btn_esc, btn_r, btn_l, btn_u, btn_d} = m;
        tick(2);
        {btn_ok, btn_esc, btn_r, btn_l, btn_u, btn_d} = 6'b0;
        tick(3);
    endtask

    task automatic enter(input logic [AW-1:0] f, input logic [AW-1:0] l, input string nm);
        first_fld = f;
        last_fld  = l;
        e_edit    = 1'b1;
        e_cur     = f;
        e_vals    = live_vals;
        push(nm, -1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
    endtask

    task automatic step(input logic [5:0] m, input int f, input logic [7:0] v, input string nm);
        e_vals[8*f +: 8] = v;
        push(nm, -1);
        press(m);
    endtask

    task automatic cur_mv(input logic [5:0] m, input logic [AW-1:0] c, input string nm);
        e_cur = c;
        push(nm, -1);
        press(m);
    endtask

    task automatic esc(input string nm);
        e_edit = 1'b0;
        push(nm, -1);
        press(6'b010000);
    endtask

    initial begin
        // fields: day, month, year, hh, mm, ss, timer hh, timer mm, timer ss
        fld_min   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        fld_max   = {8'h59, 8'h59, 8'h99, 8'h59, 8'h59, 8'h23, 8'h99, 8'h12, 8'h31};
        live_vals = {8'h03, 8'h02, 8'h01, 8'h30, 8'h00, 8'h12, 8'h24, 8'h06, 8'h15};
        tick(2);
        cur = {editing, commit, cursor, edit_vals};
        n_cmp++;
        if (cur !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h, expected 0", cur);
        end
        reset = 1'b0;
        prev   = cur;
        mon_en = 1'b1;
        tick(2);

        // reset in the middle of an edit
        enter(4'd0, 4'd8, "enter_a");
        step(6'b000010, 0, 8'h16, "day_inc_15");
        e_edit = 1'b0; e_cur = '0; e_vals = '0;
        push("reset_mid_edit", -1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);

        // increment/decrement wrap on the day field (01..31)
        live_vals[7:0] = 8'h09;
        enter(4'd0, 4'd8, "enter_b1");
        step(6'b000010, 0, 8'h10, "day_inc_09");
        esc("esc_b1");
        live_vals[7:0] = 8'h31;
        enter(4'd0, 4'd8, "enter_b2");
        step(6'b000010, 0, 8'h01, "day_inc_wrap_31");
        step(6'b000001, 0, 8'h31, "day_dec_wrap_01");
        esc("esc_b2");

        // cursor wrap in window 6..8; day above its max lies outside the window
        fld_max[7:0] = 8'h10;
        enter(4'd6, 4'd8, "enter_c");
        cur_mv(6'b000100, 4'd8, "cur_l_wrap");
        cur_mv(6'b001000, 4'd6, "cur_r_wrap");
        cur_mv(6'b000100, 4'd8, "cur_l_again");
        press(6'b001100);
        step(6'b000010, 8, 8'h04, "tss_inc_after_rl");
        esc("esc_c");
        fld_max[7:0] = 8'h31;

        // auto-repeat on the minute field
        enter(4'd4, 4'd4, "enter_d");
        n0 = cyc;
        e_vals[39:32] = 8'h01; push("rep_edge", n0 + 2);
        e_vals[39:32] = 8'h02; push("rep_dly", n0 + 12);
        e_vals[39:32] = 8'h03; push("rep_rate1", n0 + 16);
        e_vals[39:32] = 8'h04; push("rep_rate2", n0 + 20);
        btn_u = 1'b1;
        tick(20);
        btn_u = 1'b0;
        tick(3);
        esc("esc_d");

        // clamp when the day maximum drops
        live_vals[15:0] = 16'h0131;
        enter(4'd0, 4'd1, "enter_e");
        n0 = cyc;
        e_vals[7:0] = 8'h30;
        push("clamp_31_to_30", n0 + 1);
        fld_max[7:0] = 8'h30;
        tick(3);
        step(6'b000001, 0, 8'h29, "day_dec_30");
        esc("esc_e");
        fld_max[7:0] = 8'h31;

        // commit path
        live_vals[31:24] = 8'h22;
        enter(4'd3, 4'd3, "enter_f");
        step(6'b000010, 3, 8'h23, "hh_inc_22");
        n0 = cyc;
        e_edit = 1'b0; e_commit = 1'b1;
        push("commit_rise", n0 + 2);
        e_commit = 1'b0;
        push("commit_fall", n0 + 3);
        press(6'b100000);

        // esc beats ok: cancel without commit
        enter(4'd3, 4'd3, "enter_g");
        step(6'b000010, 3, 8'h23, "hh_inc_g");
        e_edit = 1'b0;
        push("esc_over_ok", -1);
        press(6'b110000);
        tick(5);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained: %0d expectations left, expected 0", q.size());
        end
        n_cmp++;
        if (n_commit != 1) begin
            n_bad++;
            $display("FAIL commit_pulses: got %0d, expected 1", n_commit);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
